dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//   Arbitrates the single-port data memory between the pipeline MEM stage (cpu) and a debug/preload loader (dbg).
//   Sequences each access through a 3-state FSM and returns read data with a one-cycle done pulse.
//   Drives the stall that freezes IF..MEM while a cpu access is pending.
//   Sits between the pipeline MEM stage, the debug loader and the synchronous data RAM.
// PARAMETERS
//   ADDR_W      32  byte-address width on both requester ports
//   DATA_W      32  data word width
//   DEPTH_WORDS 64  RAM depth in words; must be a power of 2
//   STARVE_MAX  4   consecutive cpu wins tolerated while dbg waits
// PORTS
//   clock       in   1                    single clock, rising edge
//   reset       in   1                    synchronous, active-high
//   cpu_req     in   1                    MEM-stage access request; held until cpu_done
//   cpu_we      in   1                    1 = store, 0 = load
//   cpu_addr    in   ADDR_W               byte address
//   cpu_wdata   in   DATA_W               store data
//   cpu_rdata   out  DATA_W               load data; valid while cpu_done = 1
//   cpu_done    out  1                    one-cycle completion pulse
//   cpu_stall   out  1                    cpu_req & ~cpu_done
//   dbg_req/dbg_we/dbg_addr/dbg_wdata     in;  same meaning as the cpu port
//   dbg_rdata   out  DATA_W               debug load data
//   dbg_done    out  1                    debug completion pulse
//   mem_en      out  1                    RAM enable
//   mem_we      out  1                    RAM write enable
//   mem_addr    out  $clog2(DEPTH_WORDS)  word index
//   mem_wdata   out  DATA_W               RAM write data
//   mem_rdata   in   DATA_W               RAM read data; valid 1 cycle after mem_en
//   err_misalign out 1                    sticky misaligned-access flag
// BEHAVIOUR
//   Reset values: FSM = IDLE; all *_done, mem_en, mem_we = 0; rdata regs = 0; starve counter = 0; err_misalign = 0.
//   FSM states and transitions:
//   - IDLE   -> ACCESS when any request is present; the winner's we/addr/wdata are latched.
//   - ACCESS -> RESP unconditionally; mem_en = 1, mem_we = latched we (both gated by ~reset).
//   - RESP   -> ACCESS if a request is pending (re-arbitrate), else IDLE.
//   - In RESP: mem_rdata is captured into the winner's rdata reg and the winner's done pulses.
//   Latency: request sampled in IDLE at cycle N -> mem_en at N+1 -> done at N+2.
//   Throughput: one access per 2 cycles when back-to-back.
//   Arbitration: cpu has priority, except dbg wins when dbg_req = 1 and starve count == STARVE_MAX.
//   Starve counter:
//   - +1 at each cpu grant while dbg_req = 1; saturates at STARVE_MAX.
//   - Cleared on a dbg grant or when dbg_req = 0 at arbitration.
//   Address: word index = addr[2 +: $clog2(DEPTH_WORDS)], so out-of-range addresses wrap modulo DEPTH_WORDS.
//   Misaligned (addr[1:0] != 0):
//   - FSM still takes the ACCESS/RESP path but mem_en stays 0.
//   - done pulses at N+2 with rdata = 0; err_misalign sets and holds until reset.
//   Writes: mem_wdata = latched wdata; done pulses in RESP; rdata is unchanged.
//   Both requesters' done pulses never occur in the same cycle.
//   Reset mid-operation:
//   - The memory write in flight is suppressed (mem_we gated by reset).
//   - All state returns to reset values on the next edge; the requester must re-issue.
//   Request dropped before done: the latched access still completes; the done pulse is still issued.
// STRUCTURE
//   dmem_arb_defs.vh: FSM state localparams (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2) and grant ids (GNT_CPU, GNT_DBG).
//   One natural sub-module: arb_starve_cnt (saturating counter with clear, parameter STARVE_MAX).
//   The bench supplies dmem_sync_ram (1-cycle read) as the RAM model.
// TESTING
//   1 cpu write 42 @0x0, then read @0x0 -> cpu_done at N+2 for each access; cpu_rdata = 42.
//   2 cpu and dbg held requesting, STARVE_MAX = 4 -> 4 cpu dones, then a dbg_done, then cpu resumes.
//   3 cpu read @0x6 -> mem_en stays 0; cpu_done at N+2 with rdata = 0; err_misalign = 1 until reset.
//   4 dbg write 93 @0x100 (DEPTH 64) -> mem_addr = 0; a cpu read @0x0 returns 93.
//   5 reset asserted during ACCESS of a write of 58 @0x8 -> RAM word 2 unchanged; all outputs at reset values next cycle.
//   6 cpu back-to-back reads @0x0/0x4/0x8 -> cpu_done every 2 cycles; cpu_stall low only in done cycles.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: FSM states and grant ids.
package dmem_port_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cpu wins while dbg waits; at_max_o flips priority to dbg.
// Registered count, combinational at_max_o; no backpressure.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data RAM between the cpu MEM stage and a debug loader.
// Request sampled at N -> mem_en at N+1 -> done pulse at N+2; cpu stalls until its done.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int STARVE_MAX  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_done,
  output logic                           cpu_stall,
  input  logic                           dbg_req,
  input  logic                           dbg_we,
  input  logic [ADDR_W-1:0]              dbg_addr,
  input  logic [DATA_W-1:0]              dbg_wdata,
  output logic [DATA_W-1:0]              dbg_rdata,
  output logic                           dbg_done,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           err_misalign
);

  import dmem_port_arbiter_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              misal_q, misal_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              arb_phase;
  logic              any_req;
  logic              dbg_win;
  logic              starve_at_max;
  logic [ADDR_W-1:0] sel_addr;
  logic              unused_addr_hi;

  // Arbitration happens both from IDLE and from RESP so back-to-back accesses take 2 cycles.
  assign arb_phase      = (state_q == IDLE) || (state_q == RESP);
  assign any_req        = cpu_req | dbg_req;
  assign dbg_win        = dbg_req & (~cpu_req | starve_at_max);
  assign sel_addr       = dbg_win ? dbg_addr : cpu_addr;
  assign unused_addr_hi = ^sel_addr[ADDR_W-1:IDX_W+2];

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clock    (clock),
    .reset    (reset),
    .inc_i    (arb_phase & cpu_req & dbg_req & ~dbg_win),
    .clr_i    (arb_phase & (~dbg_req | dbg_win)),
    .at_max_o (starve_at_max)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    misal_d     = misal_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ACCESS: begin
        state_d = RESP;
        err_d   = err_q | misal_q;
      end
      IDLE, RESP: begin
        if ((state_q == RESP) && !we_q) begin
          if (gnt_q == GNT_CPU) begin
            cpu_rdata_d = misal_q ? '0 : mem_rdata;
          end else begin
            dbg_rdata_d = misal_q ? '0 : mem_rdata;
          end
        end
        if (any_req) begin
          state_d = ACCESS;
          gnt_d   = dbg_win ? GNT_DBG : GNT_CPU;
          we_d    = dbg_win ? dbg_we : cpu_we;
          wdata_d = dbg_win ? dbg_wdata : cpu_wdata;
          idx_d   = sel_addr[2 +: IDX_W];
          misal_d = is_misaligned(sel_addr[1:0]);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_CPU;
      we_q        <= 1'b0;
      misal_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      misal_q     <= misal_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Reset gating keeps a write that is in flight when reset arrives from reaching the RAM.
  assign mem_en       = (state_q == ACCESS) & ~misal_q & ~reset;
  assign mem_we       = mem_en & we_q;
  assign mem_addr     = idx_q;
  assign mem_wdata    = wdata_q;
  assign cpu_done     = (state_q == RESP) & (gnt_q == GNT_CPU);
  assign dbg_done     = (state_q == RESP) & (gnt_q == GNT_DBG);
  assign cpu_rdata    = cpu_rdata_d;
  assign dbg_rdata    = dbg_rdata_d;
  assign cpu_stall    = cpu_req & ~cpu_done;
  assign err_misalign = err_q;

endmodule
